// File: rtl/descale_arbiter.sv
// descale_arbiter
//   Two-requester round-robin arbiter and result router in front of the
//   non-stallable descale multiplier pipeline. At most one operation is
//   issued per cycle. Each in-flight operation's owner (and, when tag
//   checking is built in, its tag) rides a LATENCY-deep shift register that
//   lines up with pipe_done, so every product is steered back to the
//   requester that issued it.
//
//   Optional feature: define DESCALE_ARB_TAGCHK_EN to store tags in the
//   tracking register and raise a sticky tag_err on a tag mismatch, a
//   spurious pipe_done or a missing pipe_done. Undefined: tag_err is 0.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   reqN_valid/ready             request handshake (transfer on valid && ready)
//   reqN_a/b/z/tag/natlog        request operands and side-band
//   hold                         blocks new grants; in-flight ops still drain
//   pipe_valid/a/b/z/tag/natlog  registered issue into the pipeline
//   pipe_done/product/tag_in/z_in  pipeline result
//   rspN_valid/product/tag/z     registered one-cycle response per requester
//   busy                         issue register or any tracking entry valid
//   tag_err                      sticky tag-check error
module descale_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req0_z,
  input  logic [7:0]  req0_tag,
  input  logic        req0_natlog,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [31:0] req1_z,
  input  logic [7:0]  req1_tag,
  input  logic        req1_natlog,
  input  logic        hold,
  output logic        pipe_valid,
  output logic [31:0] pipe_a,
  output logic [31:0] pipe_b,
  output logic [31:0] pipe_z,
  output logic [7:0]  pipe_tag,
  output logic        pipe_natlog,
  input  logic        pipe_done,
  input  logic [31:0] pipe_product,
  input  logic [7:0]  pipe_tag_in,
  input  logic [31:0] pipe_z_in,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_product,
  output logic [7:0]  rsp0_tag,
  output logic [31:0] rsp0_z,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_product,
  output logic [7:0]  rsp1_tag,
  output logic [31:0] rsp1_z,
  output logic        busy,
  output logic        tag_err
);

  logic grant0, grant1, xfer0, xfer1;

  // last_grant_q holds the index of the requester granted most recently.
  logic last_grant_q, last_grant_d;

  logic        pipe_valid_q, pipe_valid_d;
  logic [31:0] pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d, pipe_z_q, pipe_z_d;
  logic [7:0]  pipe_tag_q, pipe_tag_d;
  logic        pipe_natlog_q, pipe_natlog_d;
  logic        issue_owner_q, issue_owner_d;

  logic [LATENCY-1:0] trk_valid_q, trk_valid_d;
  logic [LATENCY-1:0] trk_owner_q, trk_owner_d;
  logic head_valid, head_owner, deliver;

  logic        rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_product_q, rsp0_product_d, rsp1_product_q, rsp1_product_d;
  logic [7:0]  rsp0_tag_q, rsp0_tag_d, rsp1_tag_q, rsp1_tag_d;
  logic [31:0] rsp0_z_q, rsp0_z_d, rsp1_z_q, rsp1_z_d;

  // Round-robin grant: on contention the requester not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!hold) begin
      if (req0_valid && req1_valid) begin
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer0      = req0_valid & grant0;
  assign xfer1      = req1_valid & grant1;

  // Issue register: operands hold their last value when nothing transfers.
  always_comb begin
    last_grant_d  = last_grant_q;
    pipe_valid_d  = xfer0 | xfer1;
    pipe_a_d      = pipe_a_q;
    pipe_b_d      = pipe_b_q;
    pipe_z_d      = pipe_z_q;
    pipe_tag_d    = pipe_tag_q;
    pipe_natlog_d = pipe_natlog_q;
    issue_owner_d = issue_owner_q;
    if (xfer0) begin
      pipe_a_d      = req0_a;
      pipe_b_d      = req0_b;
      pipe_z_d      = req0_z;
      pipe_tag_d    = req0_tag;
      pipe_natlog_d = req0_natlog;
      issue_owner_d = 1'b0;
      last_grant_d  = 1'b0;
    end else if (xfer1) begin
      pipe_a_d      = req1_a;
      pipe_b_d      = req1_b;
      pipe_z_d      = req1_z;
      pipe_tag_d    = req1_tag;
      pipe_natlog_d = req1_natlog;
      issue_owner_d = 1'b1;
      last_grant_d  = 1'b1;
    end
  end

  // Tracking shift register; entry LATENCY-1 is aligned with pipe_done.
  always_comb begin
    trk_valid_d = {trk_valid_q[LATENCY-2:0], pipe_valid_q};
    trk_owner_d = {trk_owner_q[LATENCY-2:0], issue_owner_q};
  end

  assign head_valid = trk_valid_q[LATENCY-1];
  assign head_owner = trk_owner_q[LATENCY-1];
  assign deliver    = head_valid & pipe_done;

  always_comb begin
    rsp0_valid_d   = deliver & ~head_owner;
    rsp1_valid_d   = deliver & head_owner;
    rsp0_product_d = rsp0_valid_d ? pipe_product : rsp0_product_q;
    rsp0_tag_d     = rsp0_valid_d ? pipe_tag_in  : rsp0_tag_q;
    rsp0_z_d       = rsp0_valid_d ? pipe_z_in    : rsp0_z_q;
    rsp1_product_d = rsp1_valid_d ? pipe_product : rsp1_product_q;
    rsp1_tag_d     = rsp1_valid_d ? pipe_tag_in  : rsp1_tag_q;
    rsp1_z_d       = rsp1_valid_d ? pipe_z_in    : rsp1_z_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q   <= 1'b1;
      pipe_valid_q   <= 1'b0;
      pipe_a_q       <= '0;
      pipe_b_q       <= '0;
      pipe_z_q       <= '0;
      pipe_tag_q     <= '0;
      pipe_natlog_q  <= 1'b0;
      issue_owner_q  <= 1'b0;
      trk_valid_q    <= '0;
      trk_owner_q    <= '0;
      rsp0_valid_q   <= 1'b0;
      rsp0_product_q <= '0;
      rsp0_tag_q     <= '0;
      rsp0_z_q       <= '0;
      rsp1_valid_q   <= 1'b0;
      rsp1_product_q <= '0;
      rsp1_tag_q     <= '0;
      rsp1_z_q       <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      pipe_valid_q   <= pipe_valid_d;
      pipe_a_q       <= pipe_a_d;
      pipe_b_q       <= pipe_b_d;
      pipe_z_q       <= pipe_z_d;
      pipe_tag_q     <= pipe_tag_d;
      pipe_natlog_q  <= pipe_natlog_d;
      issue_owner_q  <= issue_owner_d;
      trk_valid_q    <= trk_valid_d;
      trk_owner_q    <= trk_owner_d;
      rsp0_valid_q   <= rsp0_valid_d;
      rsp0_product_q <= rsp0_product_d;
      rsp0_tag_q     <= rsp0_tag_d;
      rsp0_z_q       <= rsp0_z_d;
      rsp1_valid_q   <= rsp1_valid_d;
      rsp1_product_q <= rsp1_product_d;
      rsp1_tag_q     <= rsp1_tag_d;
      rsp1_z_q       <= rsp1_z_d;
    end
  end

`ifdef DESCALE_ARB_TAGCHK_EN
  logic [7:0] trk_tag_q [LATENCY];
  logic [7:0] trk_tag_d [LATENCY];
  logic       tag_err_q, tag_err_d;

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_trk_tag
      if (gi == 0) begin : g_head_in
        assign trk_tag_d[gi] = pipe_tag_q;
      end else begin : g_shift
        assign trk_tag_d[gi] = trk_tag_q[gi-1];
      end
      always_ff @(posedge clock) begin
        if (reset) trk_tag_q[gi] <= '0;
        else       trk_tag_q[gi] <= trk_tag_d[gi];
      end
    end
  endgenerate

  // Sticky: mismatch on delivery, done without an owner, or owner without done.
  always_comb begin
    tag_err_d = tag_err_q
              | (deliver & (pipe_tag_in != trk_tag_q[LATENCY-1]))
              | (pipe_done & ~head_valid)
              | (head_valid & ~pipe_done);
  end

  always_ff @(posedge clock) begin
    if (reset) tag_err_q <= 1'b0;
    else       tag_err_q <= tag_err_d;
  end

  assign tag_err = tag_err_q;
`else
  assign tag_err = 1'b0;
`endif

  assign pipe_valid   = pipe_valid_q;
  assign pipe_a       = pipe_a_q;
  assign pipe_b       = pipe_b_q;
  assign pipe_z       = pipe_z_q;
  assign pipe_tag     = pipe_tag_q;
  assign pipe_natlog  = pipe_natlog_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp0_product = rsp0_product_q;
  assign rsp0_tag     = rsp0_tag_q;
  assign rsp0_z       = rsp0_z_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp1_product = rsp1_product_q;
  assign rsp1_tag     = rsp1_tag_q;
  assign rsp1_z       = rsp1_z_q;
  assign busy         = pipe_valid_q | (|trk_valid_q);

endmodule

// File: tb/tb_descale_arbiter.sv
// Directed testbench for descale_arbiter with a behavioural LATENCY-stage
// pipeline model. Define DESCALE_ARB_TAGCHK_EN for both files together.
module tb_descale_arbiter;
  localparam int L = 4;
`ifdef DESCALE_ARB_TAGCHK_EN
  localparam logic TAGCHK = 1'b1;
`else
  localparam logic TAGCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req0_z = 0, req1_a = 0, req1_b = 0, req1_z = 0;
  logic [7:0]  req0_tag = 0, req1_tag = 0;
  logic        req0_natlog = 0, req1_natlog = 0, hold = 0;
  logic        pipe_valid, pipe_natlog, pipe_done;
  logic [31:0] pipe_a, pipe_b, pipe_z, pipe_product, pipe_z_in;
  logic [7:0]  pipe_tag, pipe_tag_in;
  logic        rsp0_valid, rsp1_valid, busy, tag_err;
  logic [31:0] rsp0_product, rsp0_z, rsp1_product, rsp1_z;
  logic [7:0]  rsp0_tag, rsp1_tag;

  descale_arbiter #(.LATENCY(L)) dut (
    .clock(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_z(req0_z), .req0_tag(req0_tag), .req0_natlog(req0_natlog),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_z(req1_z), .req1_tag(req1_tag), .req1_natlog(req1_natlog),
    .hold(hold),
    .pipe_valid(pipe_valid), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_z(pipe_z),
    .pipe_tag(pipe_tag), .pipe_natlog(pipe_natlog),
    .pipe_done(pipe_done), .pipe_product(pipe_product), .pipe_tag_in(pipe_tag_in),
    .pipe_z_in(pipe_z_in),
    .rsp0_valid(rsp0_valid), .rsp0_product(rsp0_product), .rsp0_tag(rsp0_tag), .rsp0_z(rsp0_z),
    .rsp1_valid(rsp1_valid), .rsp1_product(rsp1_product), .rsp1_tag(rsp1_tag), .rsp1_z(rsp1_z),
    .busy(busy), .tag_err(tag_err)
  );

  // Stand-in multiplier: the 2.0*3.0 vector is a true float product, other
  // operands use a+b so routed results stay distinguishable.
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a + b;
  endfunction

  // Pipeline model, reset by the same signal as the arbiter.
  logic        pv [L];
  logic [31:0] pp [L];
  logic [31:0] pz [L];
  logic [7:0]  pt [L];
  int          done_cnt;
  logic        spur = 0, corrupt_en = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < L; i++) pv[i] <= 1'b0;
      done_cnt <= 0;
    end else begin
      pv[0] <= pipe_valid; pp[0] <= prod(pipe_a, pipe_b);
      pz[0] <= pipe_z;     pt[0] <= pipe_tag;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1]; pp[i] <= pp[i-1]; pz[i] <= pz[i-1]; pt[i] <= pt[i-1];
      end
      if (pipe_done) done_cnt <= done_cnt + 1;
    end
  end

  assign pipe_done    = pv[L-1] | spur;
  assign pipe_product = pp[L-1];
  assign pipe_z_in    = pz[L-1];
  assign pipe_tag_in  = (corrupt_en && done_cnt == 1) ? 8'hFF : pt[L-1];

  typedef struct packed { logic [7:0] tag; logic [31:0] prod; logic [31:0] z; } rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];

  always @(negedge clk) begin
    if (rsp0_valid) begin
      q0.push_back({rsp0_tag, rsp0_product, rsp0_z});
      $display("cyc %0d rsp0 tag=%02h product=%08h z=%08h", cyc, rsp0_tag, rsp0_product, rsp0_z);
    end
    if (rsp1_valid) begin
      q1.push_back({rsp1_tag, rsp1_product, rsp1_z});
      $display("cyc %0d rsp1 tag=%02h product=%08h z=%08h", cyc, rsp1_tag, rsp1_product, rsp1_z);
    end
  end

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (pipe_valid !== 1'b0) $display("FAIL reset_pipe_valid got %0b want 0", pipe_valid); else pass_cnt++;
    total_cnt++; if ({pipe_a, pipe_b, pipe_z} !== 96'h0) $display("FAIL reset_pipe_ops got %h want 0", {pipe_a, pipe_b, pipe_z}); else pass_cnt++;
    total_cnt++; if ({pipe_tag, pipe_natlog} !== 9'h0) $display("FAIL reset_pipe_tag got %h want 0", {pipe_tag, pipe_natlog}); else pass_cnt++;
    total_cnt++; if ({rsp0_valid, rsp1_valid, rsp0_product, rsp1_tag} !== 42'h0) $display("FAIL reset_rsp got %h want 0", {rsp0_valid, rsp1_valid, rsp0_product, rsp1_tag}); else pass_cnt++;
    total_cnt++; if ({busy, tag_err} !== 2'b00) $display("FAIL reset_busy_err got %b want 00", {busy, tag_err}); else pass_cnt++;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); else pass_cnt++;
    step();
  endtask

  task automatic test_contention();
    int n0 = 0, n1 = 0;
    q0.delete(); q1.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      req0_tag = 8'(n0);        req0_a = 32'(n0);        req0_b = 32'd100; req0_z = 32'hA0 + 32'(n0);
      req1_tag = 8'h10 + 8'(n1); req1_a = 32'h10 + 32'(n1); req1_b = 32'd200; req1_z = 32'hB0 + 32'(n1);
      @(negedge clk);
      total_cnt++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL contention_grant%0d got %b want %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      else pass_cnt++;
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      step();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (L + 4) step();
    total_cnt++; if (q0.size() != 3 || q1.size() != 3) $display("FAIL contention_count got %0d/%0d want 3/3", q0.size(), q1.size()); else pass_cnt++;
    for (int k = 0; k < 3 && k < q0.size() && k < q1.size(); k++) begin
      total_cnt++;
      if (q0[k] !== {8'(k), 32'(k) + 32'd100, 32'hA0 + 32'(k)})
        $display("FAIL contention_rsp0_%0d got %h want %h", k, q0[k], {8'(k), 32'(k) + 32'd100, 32'hA0 + 32'(k)});
      else pass_cnt++;
      total_cnt++;
      if (q1[k] !== {8'h10 + 8'(k), 32'h10 + 32'(k) + 32'd200, 32'hB0 + 32'(k)})
        $display("FAIL contention_rsp1_%0d got %h want %h", k, q1[k], {8'h10 + 8'(k), 32'h10 + 32'(k) + 32'd200, 32'hB0 + 32'(k)});
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int c, seen = -1;
    logic r1_seen = 0;
    req0_a = 32'h4000_0000; req0_b = 32'h4040_0000; req0_z = 32'h1234; req0_tag = 8'h11;
    req0_valid = 1;
    @(negedge clk);
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL single_ready got %b want 1", req0_ready); else pass_cnt++;
    c = cyc;
    step(); req0_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp1_valid) r1_seen = 1;
      if (rsp0_valid && seen < 0) begin
        seen = cyc;
        total_cnt++;
        if ({rsp0_product, rsp0_tag, rsp0_z} !== {32'h40C0_0000, 8'h11, 32'h1234})
          $display("FAIL single_data got %h want %h", {rsp0_product, rsp0_tag, rsp0_z}, {32'h40C0_0000, 8'h11, 32'h1234});
        else pass_cnt++;
      end
      step();
    end
    total_cnt++; if (seen != c + L + 2) $display("FAIL single_latency got cycle %0d want %0d", seen, c + L + 2); else pass_cnt++;
    total_cnt++; if (r1_seen !== 1'b0) $display("FAIL single_rsp1 got %b want 0", r1_seen); else pass_cnt++;
  endtask

  task automatic test_hold();
    int c_last = 0, fell = -1;
    q0.delete(); q1.delete();
    req0_valid = 1; req0_b = 32'd5; req0_z = 0;
    for (int i = 0; i < 2; i++) begin
      req0_tag = 8'h20 + 8'(i); req0_a = 32'h20 + 32'(i);
      @(negedge clk);
      total_cnt++; if (req0_ready !== 1'b1) $display("FAIL hold_pre_ready%0d got %b want 1", i, req0_ready); else pass_cnt++;
      c_last = cyc;
      step();
    end
    hold = 1; req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL hold_ready%0d got %b want 00", i, {req0_ready, req1_ready}); else pass_cnt++;
      total_cnt++; if (pipe_valid !== (i == 0)) $display("FAIL hold_pipe_valid%0d got %b want %b", i, pipe_valid, (i == 0)); else pass_cnt++;
      step();
    end
    hold = 0; req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    total_cnt++; if (pipe_valid !== 1'b0) $display("FAIL hold_pipe_valid_after got %b want 0", pipe_valid); else pass_cnt++;
    for (int i = 0; i < 20 && fell < 0; i++) begin
      if (busy === 1'b0) fell = cyc;
      else begin step(); @(negedge clk); end
    end
    total_cnt++; if (fell != c_last + L + 2) $display("FAIL hold_busy_fall got cycle %0d want %0d", fell, c_last + L + 2); else pass_cnt++;
    step(); step();
    total_cnt++;
    if (q0.size() != 2 || q1.size() != 0) $display("FAIL hold_drain_count got %0d/%0d want 2/0", q0.size(), q1.size());
    else if (q0[0].tag !== 8'h20 || q0[1].tag !== 8'h21) $display("FAIL hold_drain_tags got %h,%h want 20,21", q0[0].tag, q0[1].tag);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    req0_valid = 1; req0_b = 0;
    for (int i = 0; i < 3; i++) begin
      req0_tag = 8'h30 + 8'(i); req0_a = 32'h30 + 32'(i);
      step();
    end
    req0_valid = 0;
    q0.delete(); q1.delete();
    do_reset();
    @(negedge clk);
    total_cnt++; if ({busy, pipe_valid} !== 2'b00) $display("FAIL midop_busy got %b want 00", {busy, pipe_valid}); else pass_cnt++;
    repeat (2 * L + 2) step();
    total_cnt++; if (q0.size() + q1.size() != 0) $display("FAIL midop_no_rsp got %0d want 0", q0.size() + q1.size()); else pass_cnt++;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL midop_last_grant got %b want 10", {req0_ready, req1_ready}); else pass_cnt++;
    step(); req0_valid = 0; req1_valid = 0;
    repeat (L + 4) step();
  endtask

  task automatic test_tag();
    int k = 0;
    do_reset();
    corrupt_en = 1;
    req1_valid = 1; req1_b = 1; req1_z = 0;
    for (int i = 0; i < 2; i++) begin
      req1_tag = 8'h40 + 8'(i); req1_a = 32'h40 + 32'(i);
      step();
    end
    req1_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp1_valid) begin
        total_cnt++;
        if (rsp1_tag !== ((k == 0) ? 8'h40 : 8'hFF)) $display("FAIL tag_rsp%0d got %h want %h", k, rsp1_tag, (k == 0) ? 8'h40 : 8'hFF); else pass_cnt++;
        total_cnt++;
        if (tag_err !== ((k == 0) ? 1'b0 : TAGCHK)) $display("FAIL tag_err_at%0d got %b want %b", k, tag_err, (k == 0) ? 1'b0 : TAGCHK); else pass_cnt++;
        k++;
      end
      step();
    end
    corrupt_en = 0;
    total_cnt++; if (k != 2) $display("FAIL tag_rsp_count got %0d want 2", k); else pass_cnt++;
    total_cnt++; if (tag_err !== TAGCHK) $display("FAIL tag_err_sticky got %b want %b", tag_err, TAGCHK); else pass_cnt++;
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    total_cnt++; if (tag_err !== 1'b0) $display("FAIL spur_err_cleared got %b want 0", tag_err); else pass_cnt++;
    step();
    spur = 1; step(); spur = 0;
    @(negedge clk);
    total_cnt++; if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL spur_no_rsp got %b want 00", {rsp0_valid, rsp1_valid}); else pass_cnt++;
    total_cnt++; if (tag_err !== TAGCHK) $display("FAIL spur_tag_err got %b want %b", tag_err, TAGCHK); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_hold();
    test_reset_midop();
    test_tag();
    test_spurious();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/descale_arbiter.md
# descale_arbiter

Two-requester round-robin arbiter and result router in front of the 4-stage descale multiplier pipeline (a × b with z/tag side-band). Issues at most one operation per cycle into the non-stallable pipeline. Tracks the owner and tag of every in-flight operation in a LATENCY-deep shift register. Steers each returning product back to the requester that issued it. Sits between the two CORDIC scale-output lanes and the shared descale multiplier.

## Interface
Parameters:
- LATENCY, 4, cycles from `pipe_valid` high to the matching `pipe_done` high; legal range 2..16.

Ports (clock and reset first):
- clock  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  grant; the operation transfers when valid && ready.
- req0_a / req1_a  in  32  multiplicand.
- req0_b / req1_b  in  32  multiplier.
- req0_z / req1_z  in  32  z side-band.
- req0_tag / req1_tag  in  8  instruction tag.
- req0_natlog / req1_natlog  in  1  NatLog flag.
- hold  in  1  blocks new grants; in-flight operations still drain.
- pipe_valid  out  1  drives the pipeline ScaleValid.
- pipe_a, pipe_b, pipe_z  out  32  operands and z to the pipeline.
- pipe_tag  out  8  tag to the pipeline.
- pipe_natlog  out  1  NatLog flag to the pipeline.
- pipe_done  in  1  pipeline done.
- pipe_product  in  32  FinalProduct.
- pipe_tag_in  in  8  returned tag.
- pipe_z_in  in  32  returned z.
- rsp0_valid / rsp1_valid  out  1  one-cycle result strobe for requester n.
- rsp0_product / rsp1_product  out  32  product.
- rsp0_tag / rsp1_tag  out  8  tag.
- rsp0_z / rsp1_z  out  32  z.
- busy  out  1  high when any operation is in flight or `pipe_valid` is high.
- tag_err  out  1  sticky tag-mismatch flag; see Configuration.

## Operation
Grant logic (combinational):
- Grants are disabled while `hold` is high.
- If only one requester is valid, it gets ready.
- If both are valid, the requester that was not granted last gets ready.
- `last_grant` resets to 1, so requester 0 wins the first contention.
- `last_grant` updates only when a transfer actually occurs.
- At most one ready is high per cycle.

Issue stage:
- All `pipe_*` outputs are registered.
- On a transfer in cycle c, the winner's fields appear on `pipe_*` in cycle c+1 with `pipe_valid`=1.
- With no transfer, `pipe_valid`=0. Operand registers hold their last value.

Tracking:
- The shift register is LATENCY entries of {valid, owner, tag}.
- Entry 0 is loaded from the issue register each cycle.
- Entry LATENCY-1 lines up with `pipe_done`.
- The pipeline has no backpressure. Requesters must sink responses unconditionally.

Routing:
- When the tracked entry at the head is valid and `pipe_done`=1, `rspN_valid` pulses for the recorded owner.
- In that case, `rspN_product`, `rspN_tag` and `rspN_z` are registered from the pipe inputs. Response latency is one cycle after `pipe_done`.
- If `pipe_done`=1 while the head entry is invalid, the result is discarded. If tag check is compiled in, `tag_err` is set.
- If the head entry is valid while `pipe_done`=0, the entry is dropped and no response is produced. If tag check is compiled in, `tag_err` is set.

`busy` = `pipe_valid` OR any tracking entry is valid.

## Timing
- Throughput: one operation per cycle, sustained.
- Alternation: with both requesters continuously valid, grants alternate 0,1,0,1.
- End-to-end latency: request transfer in cycle c → `rspN_valid` in cycle c+LATENCY+2.
- Reset values: `pipe_valid`=0, `pipe_a`/`pipe_b`/`pipe_z`=0, `pipe_tag`=0, `pipe_natlog`=0, all `rsp*` outputs 0, `busy`=0, `tag_err`=0, `last_grant`=1, all tracking entries invalid.
- Reset mid-operation: all in-flight tracking is cleared. Products that return later are discarded.
- Reset sets the tracking state only. It does not clear the pipeline itself; the pipeline is reset by the same signal.
- `hold` asserted in cycle c: no transfer occurs in cycle c. Operations already issued still return.
- `hold` is not a flush.

## Configuration
- DESCALE_ARB_TAGCHK_EN defined:
  - On every valid head entry with `pipe_done`=1, compare `pipe_tag_in` against the recorded tag.
  - A mismatch sets `tag_err` on the next cycle. The response is still delivered.
  - The spurious-done and missing-done cases above also set `tag_err`.
  - `tag_err` clears only on reset.
- Not defined: tags are not stored in the tracking register, `tag_err` is tied to 0, and routing is unchanged.

## Test plan
- Single op: req0 with a=0x40000000 (2.0), b=0x40400000 (3.0), tag=0x11 → `rsp0_valid` at c+LATENCY+2 with product 0x40C00000 and tag 0x11; `rsp1_valid` stays 0.
- Contention: both requesters valid for 6 cycles with tags 0x0n/0x1n → grant order 0,1,0,1,0,1; each rsp port receives exactly 3 results in issue order.
- Hold: `hold`=1 for 3 cycles mid-stream → ready is 0 on both ports, `pipe_valid` is 0 one cycle later, prior results still return, `busy` falls after the drain.
- Reset with 3 ops in flight → no `rsp*_valid` pulses afterwards, `busy`=0 the cycle after reset, `last_grant` restored (req0 wins the next contention).
- DESCALE_ARB_TAGCHK_EN: bench corrupts `pipe_tag_in` to 0xFF on the second result → `tag_err`=1 the next cycle and stays high; the response is still delivered. With the macro undefined, `tag_err` stays 0.
- Spurious `pipe_done` with nothing in flight → no response; `tag_err` is set only when the macro is defined.
